// File: rtl/issue_ctrl_pkg.sv
// rtl/issue_ctrl_pkg.sv - shared types and control constants for the decode-stage issue controller
package issue_ctrl_pkg;

    localparam int REG_AW = 5;
    localparam int INFL_W = 2;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        FREEZE = 2'd1,
        DRAIN  = 2'd2
    } issue_state_t;

    typedef struct packed {
        logic stall_f;
        logic stall_d;
        logic bubble_e;
        logic flush_d;
        logic freeze;
    } hazard_ctl_t;

    localparam hazard_ctl_t CTL_NONE   = '{stall_f: 1'b0, stall_d: 1'b0, bubble_e: 1'b0, flush_d: 1'b0, freeze: 1'b0};
    localparam hazard_ctl_t CTL_STALL  = '{stall_f: 1'b1, stall_d: 1'b1, bubble_e: 1'b1, flush_d: 1'b0, freeze: 1'b0};
    localparam hazard_ctl_t CTL_FREEZE = '{stall_f: 1'b1, stall_d: 1'b1, bubble_e: 1'b0, flush_d: 1'b0, freeze: 1'b1};
    localparam hazard_ctl_t CTL_FLUSH  = '{stall_f: 1'b0, stall_d: 1'b0, bubble_e: 1'b1, flush_d: 1'b1, freeze: 1'b0};
    localparam hazard_ctl_t CTL_RESET  = '{stall_f: 1'b0, stall_d: 1'b0, bubble_e: 1'b0, flush_d: 1'b1, freeze: 1'b0};

endpackage

// File: rtl/issue_ctrl_scoreboard.sv
// rtl/issue_ctrl_scoreboard.sv - per-register pending-write counters, RAW lookup and in-flight count
module issue_ctrl_scoreboard
    import issue_ctrl_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              hold_i,
    input  logic [REG_AW-1:0] ra1_i,
    input  logic [REG_AW-1:0] ra2_i,
    input  logic              inc_en_i,
    input  logic [REG_AW-1:0] inc_dst_i,
    input  logic              dec_en_i,
    input  logic [REG_AW-1:0] dec_dst_i,
    output logic              haz1_o,
    output logic              haz2_o,
    output logic [INFL_W-1:0] inflight_o
);

    localparam logic [CNT_W-1:0]  CNT_MAX  = '1;
    localparam logic [INFL_W-1:0] INFL_MAX = '1;

    logic [CNT_W-1:0]  cnt_q [NREG];
    logic [CNT_W-1:0]  cnt_d [NREG];
    logic [INFL_W-1:0] inflight_q, inflight_d;
    logic              inc_any, dec_any;
    logic              cnt_err, infl_err;

    assign inc_any = inc_en_i && (inc_dst_i != '0);
    assign dec_any = dec_en_i && (dec_dst_i != '0);

    // A writer whose last pending copy retires this cycle is already visible
    // to a write-before-read register file, so it no longer blocks the reader.
    always_comb begin
        haz1_o = 1'b0;
        haz2_o = 1'b0;
        for (int r = 1; r < NREG; r++) begin
            if (cnt_q[r] != '0 &&
                !(WB_BYPASS && cnt_q[r] == CNT_W'(1) && dec_any && dec_dst_i == REG_AW'(r))) begin
                if (ra1_i == REG_AW'(r)) haz1_o = 1'b1;
                if (ra2_i == REG_AW'(r)) haz2_o = 1'b1;
            end
        end
    end

    always_comb begin
        cnt_err  = 1'b0;
        cnt_d[0] = '0;
        for (int r = 1; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            if (inc_any && inc_dst_i == REG_AW'(r) && !(dec_any && dec_dst_i == REG_AW'(r))) begin
                if (cnt_q[r] == CNT_MAX) cnt_err = 1'b1;
                else                     cnt_d[r] = cnt_q[r] + CNT_W'(1);
            end else if (dec_any && dec_dst_i == REG_AW'(r) && !(inc_any && inc_dst_i == REG_AW'(r))) begin
                if (cnt_q[r] == '0) cnt_err = 1'b1;
                else                cnt_d[r] = cnt_q[r] - CNT_W'(1);
            end
        end
    end

    always_comb begin
        infl_err   = 1'b0;
        inflight_d = inflight_q;
        if (inc_any && !dec_any) begin
            if (inflight_q == INFL_MAX) infl_err = 1'b1;
            else                        inflight_d = inflight_q + INFL_W'(1);
        end else if (dec_any && !inc_any) begin
            if (inflight_q == '0) infl_err = 1'b1;
            else                  inflight_d = inflight_q - INFL_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int r = 0; r < NREG; r++) cnt_q[r] <= '0;
            inflight_q <= '0;
        end else if (!hold_i) begin
            cnt_q      <= cnt_d;
            inflight_q <= inflight_d;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && !hold_i) begin
            assert (!(cnt_err || infl_err));
        end
    end

    assign inflight_o = inflight_q;

endmodule

// File: rtl/issue_ctrl.sv
// rtl/issue_ctrl.sv - decode-stage issue controller: RAW stalls, redirect flush, memory freeze, serial drain
module issue_ctrl
    import issue_ctrl_pkg::*;
#(
    parameter int NREG      = 32,
    parameter int CNT_W     = 2,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              d_valid,
    input  logic [REG_AW-1:0] d_ra1,
    input  logic [REG_AW-1:0] d_ra2,
    input  logic              d_use1,
    input  logic              d_use2,
    input  logic [REG_AW-1:0] d_dst,
    input  logic              d_wr,
    input  logic              d_serial,
    input  logic              e_redirect,
    input  logic              dmem_busy,
    input  logic              wb_valid,
    input  logic [REG_AW-1:0] wb_dst,
    input  logic              wb_wr,
    output logic              stall_f,
    output logic              stall_d,
    output logic              bubble_e,
    output logic              flush_d,
    output logic              freeze,
    output logic              issue,
    output logic [INFL_W-1:0] inflight
);

    issue_state_t      state_q, saved_q, eff_state;
    hazard_ctl_t       ctl;
    logic              haz1, haz2;
    logic              raw_stall, serial_wait, issue_w;
    logic [INFL_W-1:0] sb_inflight;

    issue_ctrl_scoreboard #(
        .NREG      (NREG),
        .CNT_W     (CNT_W),
        .WB_BYPASS (WB_BYPASS)
    ) u_scoreboard (
        .clk        (clk),
        .reset      (reset),
        .hold_i     (dmem_busy),
        .ra1_i      (d_ra1),
        .ra2_i      (d_ra2),
        .inc_en_i   (issue_w && d_wr),
        .inc_dst_i  (d_dst),
        .dec_en_i   (wb_valid && wb_wr),
        .dec_dst_i  (wb_dst),
        .haz1_o     (haz1),
        .haz2_o     (haz2),
        .inflight_o (sb_inflight)
    );

    // FREEZE only remembers where to resume; the cycle busy drops already behaves as that state.
    assign eff_state = (state_q == FREEZE) ? saved_q : state_q;

    assign serial_wait = (eff_state == DRAIN) ? (sb_inflight != '0)
                                              : (d_valid && d_serial && sb_inflight != '0);
    assign raw_stall   = d_valid && ((d_use1 && haz1) || (d_use2 && haz2));

    always_comb begin
        ctl     = CTL_NONE;
        issue_w = 1'b0;
        if (reset) begin
            ctl = CTL_RESET;
        end else if (dmem_busy) begin
            ctl = CTL_FREEZE;
        end else if (e_redirect) begin
            ctl = CTL_FLUSH;
        end else if (serial_wait || raw_stall) begin
            ctl = CTL_STALL;
        end else begin
            issue_w = d_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RUN;
            saved_q <= RUN;
        end else if (dmem_busy) begin
            state_q <= FREEZE;
            saved_q <= eff_state;
        end else if (e_redirect) begin
            state_q <= RUN;
            saved_q <= RUN;
        end else begin
            saved_q <= RUN;
            case (eff_state)
                DRAIN:   state_q <= (sb_inflight == '0) ? RUN : DRAIN;
                default: state_q <= (d_valid && d_serial && sb_inflight != '0) ? DRAIN : RUN;
            endcase
        end
    end

    assign stall_f  = ctl.stall_f;
    assign stall_d  = ctl.stall_d;
    assign bubble_e = ctl.bubble_e;
    assign flush_d  = ctl.flush_d;
    assign freeze   = ctl.freeze;
    assign issue    = issue_w;
    assign inflight = reset ? '0 : sb_inflight;

endmodule

// File: tb/tb_issue_ctrl.sv
// tb/tb_issue_ctrl.sv - directed bench with a scoreboard-level reference model for issue_ctrl
module tb_issue_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic       d_valid, d_use1, d_use2, d_wr, d_serial;
    logic [4:0] d_ra1, d_ra2, d_dst;
    logic       e_redirect, dmem_busy;
    logic       wb_valid, wb_wr;
    logic [4:0] wb_dst;
    logic       stall_f, stall_d, bubble_e, flush_d, freeze, issue;
    logic [1:0] inflight;

    int n_chk  = 0;
    int n_fail = 0;

    int m_cnt [32];
    int m_infl = 0;
    bit m_drain = 1'b0;

    // {stall_f, stall_d, bubble_e, flush_d, freeze, issue}
    localparam logic [5:0] L_RUN = 6'b000000;
    localparam logic [5:0] L_ISS = 6'b000001;
    localparam logic [5:0] L_STL = 6'b111000;
    localparam logic [5:0] L_FRZ = 6'b110010;
    localparam logic [5:0] L_FLS = 6'b001100;
    localparam logic [5:0] L_RST = 6'b000100;

    issue_ctrl dut (
        .clk        (clk),
        .reset      (reset),
        .d_valid    (d_valid),
        .d_ra1      (d_ra1),
        .d_ra2      (d_ra2),
        .d_use1     (d_use1),
        .d_use2     (d_use2),
        .d_dst      (d_dst),
        .d_wr       (d_wr),
        .d_serial   (d_serial),
        .e_redirect (e_redirect),
        .dmem_busy  (dmem_busy),
        .wb_valid   (wb_valid),
        .wb_dst     (wb_dst),
        .wb_wr      (wb_wr),
        .stall_f    (stall_f),
        .stall_d    (stall_d),
        .bubble_e   (bubble_e),
        .flush_d    (flush_d),
        .freeze     (freeze),
        .issue      (issue),
        .inflight   (inflight)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    function automatic bit m_haz(input logic [4:0] r);
        return (r != 5'd0) && (m_cnt[r] > 0) &&
               !(m_cnt[r] == 1 && wb_valid && wb_wr && wb_dst == r);
    endfunction

    // Reference: outputs from the priority rules, then advance counts for the coming edge.
    always @(negedge clk) begin
        logic [5:0] e_ctl;
        int         e_inf;
        bit         wait_s, raw;
        e_ctl  = L_RUN;
        e_inf  = m_infl;
        wait_s = 1'b0;
        raw    = 1'b0;
        if (reset) begin
            e_ctl = L_RST;
            e_inf = 0;
        end else if (dmem_busy) begin
            e_ctl = L_FRZ;
        end else if (e_redirect) begin
            e_ctl = L_FLS;
        end else begin
            wait_s = (m_infl != 0) && (m_drain || (d_valid && d_serial));
            raw    = d_valid && ((d_use1 && m_haz(d_ra1)) || (d_use2 && m_haz(d_ra2)));
            if (wait_s || raw) e_ctl = L_STL;
            else               e_ctl = {5'b00000, d_valid};
        end
        chk("cmp ctl", {26'd0, stall_f, stall_d, bubble_e, flush_d, freeze, issue}, {26'd0, e_ctl});
        chk("cmp inflight", {30'd0, inflight}, e_inf);

        if (reset) begin
            for (int r = 0; r < 32; r++) m_cnt[r] = 0;
            m_infl  = 0;
            m_drain = 1'b0;
        end else if (!dmem_busy) begin
            if (e_ctl[0] && d_wr && d_dst != 5'd0) begin
                m_cnt[d_dst]++;
                m_infl++;
            end
            if (wb_valid && wb_wr && wb_dst != 5'd0) begin
                m_cnt[wb_dst]--;
                m_infl--;
            end
            m_drain = e_redirect ? 1'b0 : wait_s;
        end
    end

    task automatic clr();
        reset = 0; d_valid = 0; d_ra1 = 0; d_ra2 = 0; d_use1 = 0; d_use2 = 0;
        d_dst = 0; d_wr = 0; d_serial = 0; e_redirect = 0; dmem_busy = 0;
        wb_valid = 0; wb_dst = 0; wb_wr = 0;
    endtask

    task automatic set_d(input logic [4:0] r1, input logic u1, input logic [4:0] r2, input logic u2,
                         input logic [4:0] dst, input logic wr, input logic ser);
        d_valid = 1; d_ra1 = r1; d_use1 = u1; d_ra2 = r2; d_use2 = u2;
        d_dst = dst; d_wr = wr; d_serial = ser;
    endtask

    task automatic set_wb(input logic [4:0] dst);
        wb_valid = 1; wb_dst = dst; wb_wr = 1;
    endtask

    task automatic cyc(input string nm, input logic [5:0] exp_ctl, input int exp_inf);
        #1;
        chk({nm, " ctl"}, {26'd0, stall_f, stall_d, bubble_e, flush_d, freeze, issue}, {26'd0, exp_ctl});
        chk({nm, " inflight"}, {30'd0, inflight}, exp_inf);
        @(posedge clk);
        #1;
        clr();
    endtask

    initial begin
        #100000;
        n_fail++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    initial begin
        for (int r = 0; r < 32; r++) m_cnt[r] = 0;
        clr();
        reset = 1; set_d(0, 0, 0, 0, 5'd3, 1, 0);
        cyc("reset1", L_RST, 0);
        reset = 1;
        cyc("reset2", L_RST, 0);

        // RAW on x5 with same-cycle writeback release
        set_d(0, 0, 0, 0, 5'd5, 1, 0);                     cyc("raw issue x5", L_ISS, 0);
        set_d(5'd5, 1, 0, 0, 5'd6, 1, 0);                  cyc("raw stall a", L_STL, 1);
        set_d(5'd5, 1, 0, 0, 5'd6, 1, 0);                  cyc("raw stall b", L_STL, 1);
        set_d(5'd5, 1, 0, 0, 5'd6, 1, 0); set_wb(5'd5);    cyc("raw wb bypass", L_ISS, 1);
        chk("model cnt5", m_cnt[5], 0);

        // x0 never tracked
        set_d(0, 0, 0, 0, 5'd0, 1, 0);                     cyc("x0 write", L_ISS, 1);
        set_d(5'd0, 1, 5'd0, 1, 0, 0, 0);                  cyc("x0 read", L_ISS, 1);
        set_wb(5'd6);                                      cyc("retire x6", L_RUN, 1);

        // simultaneous inc/dec on x7
        set_d(0, 0, 0, 0, 5'd7, 1, 0);                     cyc("issue x7", L_ISS, 0);
        set_d(0, 0, 0, 0, 5'd7, 1, 0); set_wb(5'd7);       cyc("x7 inc+dec", L_ISS, 1);
        chk("model cnt7", m_cnt[7], 1);
        set_d(0, 0, 5'd7, 1, 0, 0, 0);                     cyc("x7 read stall", L_STL, 1);
        set_d(0, 0, 5'd7, 1, 0, 0, 0); set_wb(5'd7);       cyc("x7 read release", L_ISS, 1);

        // serial drain of two writers
        set_d(0, 0, 0, 0, 5'd8, 1, 0);                     cyc("issue x8", L_ISS, 0);
        set_d(0, 0, 0, 0, 5'd9, 1, 0);                     cyc("issue x9", L_ISS, 1);
        set_d(0, 0, 0, 0, 0, 0, 1);                        cyc("fence enter", L_STL, 2);
        set_d(0, 0, 0, 0, 0, 0, 1); set_wb(5'd8);          cyc("drain wb8", L_STL, 2);
        set_d(0, 0, 0, 0, 0, 0, 1); set_wb(5'd9);          cyc("drain wb9", L_STL, 1);
        set_d(0, 0, 0, 0, 0, 0, 1);                        cyc("fence issue", L_ISS, 0);
        chk("model drain clear", m_drain, 0);
                                                           cyc("idle", L_RUN, 0);

        // freeze during a RAW stall; writeback ignored while frozen
        set_d(0, 0, 0, 0, 5'd10, 1, 0);                    cyc("issue x10", L_ISS, 0);
        set_d(5'd10, 1, 0, 0, 0, 0, 0);                    cyc("x10 stall", L_STL, 1);
        for (int i = 0; i < 3; i++) begin
            set_d(5'd10, 1, 0, 0, 0, 0, 0); set_wb(5'd10); dmem_busy = 1;
            cyc("frozen", L_FRZ, 1);
        end
        set_d(5'd10, 1, 0, 0, 0, 0, 0);                    cyc("unfrozen stall", L_STL, 1);
        set_d(5'd10, 1, 0, 0, 0, 0, 0); set_wb(5'd10);     cyc("unfrozen release", L_ISS, 1);

        // redirect while draining
        set_d(0, 0, 0, 0, 5'd11, 1, 0);                    cyc("issue x11", L_ISS, 0);
        set_d(0, 0, 0, 0, 0, 0, 1);                        cyc("drain x11 a", L_STL, 1);
        set_d(0, 0, 0, 0, 0, 0, 1);                        cyc("drain x11 b", L_STL, 1);
        set_d(0, 0, 0, 0, 0, 0, 1); e_redirect = 1;        cyc("redirect", L_FLS, 1);
        set_d(0, 0, 0, 0, 0, 0, 0);                        cyc("back in run", L_ISS, 1);
        set_d(5'd11, 1, 0, 0, 0, 0, 0);                    cyc("x11 intact", L_STL, 1);

        // reset while frozen
        dmem_busy = 1;                                     cyc("freeze a", L_FRZ, 1);
        dmem_busy = 1;                                     cyc("freeze b", L_FRZ, 1);
        dmem_busy = 1; reset = 1;                          cyc("reset in freeze", L_RST, 0);
        set_d(5'd11, 1, 0, 0, 0, 0, 0);                    cyc("after reset", L_ISS, 0);

        // freeze beats redirect and resumes the drain
        set_d(0, 0, 0, 0, 5'd12, 1, 0);                    cyc("issue x12", L_ISS, 0);
        set_d(0, 0, 0, 0, 0, 0, 1);                        cyc("drain x12", L_STL, 1);
        set_d(0, 0, 0, 0, 0, 0, 1); dmem_busy = 1; e_redirect = 1;
                                                           cyc("busy over redirect", L_FRZ, 1);
        set_d(0, 0, 0, 0, 0, 0, 1); set_wb(5'd12);         cyc("resume drain", L_STL, 1);
        set_d(0, 0, 0, 0, 0, 0, 1);                        cyc("fence after resume", L_ISS, 0);

        // sources without use flags never stall
        set_d(0, 0, 0, 0, 5'd13, 1, 0);                    cyc("issue x13", L_ISS, 0);
        set_d(5'd13, 0, 5'd13, 0, 0, 0, 0);                cyc("unused sources", L_ISS, 1);
        set_wb(5'd13);                                     cyc("retire x13", L_RUN, 1);
                                                           cyc("final idle", L_RUN, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
